// File: rtl/fifo_pkg.sv
// Shared types and default widths for the FIFO pointer/flag controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fifo_pkg;

    // Coarse occupancy status tracked by the controller
    typedef enum logic [1:0] {
        VACIO  = 2'b00,
        ACTIVO = 2'b01,
        LLENO  = 2'b10
    } fifo_state_t;

    localparam int FIFO_DATA_WIDTH = 8;
    localparam int FIFO_ADDR_WIDTH = 8;

endpackage

// File: rtl/fifo_ptr.sv
// Wrap-around pointer register; advances by one when inc is high.
// Latency: new pointer visible one clk after inc.
// Backpressure: none; caller gates inc.
// Ports: clk, reset_L (async active-low), inc (advance), ptr (current value).
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  inc,
    output logic [ADDR_WIDTH-1:0] ptr
);

    // DEPTH is a power of two, so natural overflow gives the DEPTH-1 -> 0 wrap
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + ADDR_WIDTH'(1);
        end
    end

endmodule

// File: rtl/fifo_control.sv
// Pointer/flag controller in front of a registered-read FIFO memory.
// Latency: popped word and data_out_valid appear one clk after the accepted pop.
// Backpressure: push on full (without pop) is dropped, pop on empty is ignored.
// Ports: push/data_in and pop requests; mem_* drive the memory (write enable,
// data, pointers) and mem_data_out returns its registered read; data_out /
// data_out_valid return popped words; empty/full/almost_* and count report
// occupancy. Optional macro FIFO_ERR_FLAGS_EN adds sticky overflow/underflow.
module fifo_control
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH      = FIFO_DATA_WIDTH,
    parameter int ADDR_WIDTH      = FIFO_ADDR_WIDTH,
    parameter int ALMOST_FULL_TH  = (2 ** ADDR_WIDTH) - 2,
    parameter int ALMOST_EMPTY_TH = 2
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_out_valid,
    output logic                  mem_wr_en,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    output logic [ADDR_WIDTH-1:0] mem_wr_ptr,
    output logic [ADDR_WIDTH-1:0] mem_rd_ptr,
    input  logic [DATA_WIDTH-1:0] mem_data_out,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   count
`ifdef FIFO_ERR_FLAGS_EN
    ,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    localparam int                DEPTH   = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_TH   = (ADDR_WIDTH + 1)'(ALMOST_FULL_TH);
    localparam logic [ADDR_WIDTH:0] AE_TH   = (ADDR_WIDTH + 1)'(ALMOST_EMPTY_TH);

    logic                push_acc;
    logic                pop_acc;
    logic [ADDR_WIDTH:0] count_nxt;
    fifo_state_t         state;
    fifo_state_t         state_nxt;

    // A pop frees a slot in the same cycle, so push on full is legal with pop.
    // On empty the pop is rejected but the push still lands.
    assign pop_acc     = pop & ~empty;
    assign push_acc    = push & (~full | pop);
    assign mem_wr_en   = push_acc;
    assign mem_data_in = data_in;
    assign data_out    = mem_data_out;
    assign count_nxt   = count + (ADDR_WIDTH + 1)'(push_acc) - (ADDR_WIDTH + 1)'(pop_acc);

    fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_ptr (
        .clk     (clk),
        .reset_L (reset_L),
        .inc     (push_acc),
        .ptr     (mem_wr_ptr)
    );

    fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_ptr (
        .clk     (clk),
        .reset_L (reset_L),
        .inc     (pop_acc),
        .ptr     (mem_rd_ptr)
    );

    // Flags are registered from the next count so they line up with count
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            count          <= '0;
            empty          <= 1'b1;
            full           <= 1'b0;
            almost_empty   <= 1'b1;
            almost_full    <= (AF_TH == '0);
            data_out_valid <= 1'b0;
        end else begin
            count          <= count_nxt;
            empty          <= (count_nxt == '0);
            full           <= (count_nxt == DEPTH_C);
            almost_empty   <= (count_nxt <= AE_TH);
            almost_full    <= (count_nxt >= AF_TH);
            // The memory captures mem[rd_ptr] on the same edge as the pop
            data_out_valid <= pop_acc;
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push & full & ~pop) begin
                overflow <= 1'b1;
            end
            if (pop & empty) begin
                underflow <= 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state <= VACIO;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            VACIO: begin
                if (push_acc) begin
                    state_nxt = ACTIVO;
                end
            end
            ACTIVO: begin
                if (count_nxt == DEPTH_C) begin
                    state_nxt = LLENO;
                end else if (count_nxt == '0) begin
                    state_nxt = VACIO;
                end
            end
            LLENO: begin
                if (pop_acc && !push) begin
                    state_nxt = ACTIVO;
                end
            end
            default: state_nxt = VACIO;
        endcase
    end

endmodule

// File: tb/tb_fifo_control.sv
// Directed bench for fifo_control with DEPTH 8 and a registered-read memory model.
// Latency: checks sampled 1 time unit after each rising clk edge.
// Backpressure: exercises push-on-full, pop-on-empty and simultaneous push/pop.
module tb_fifo_control;

    localparam int DW = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          reset_L = 1'b0;
    logic          push = 1'b0;
    logic          pop = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic          data_out_valid;
    logic          mem_wr_en;
    logic [DW-1:0] mem_data_in;
    logic [AW-1:0] mem_wr_ptr;
    logic [AW-1:0] mem_rd_ptr;
    logic [DW-1:0] mem_data_out;
    logic          empty;
    logic          full;
    logic          almost_empty;
    logic          almost_full;
    logic [AW:0]   count;
`ifdef FIFO_ERR_FLAGS_EN
    logic          overflow;
    logic          underflow;
`endif

    logic [DW-1:0] mem [0:7];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // Storage memory: write and registered read on the same edge
    always @(posedge clk) begin
        if (mem_wr_en) begin
            mem[mem_wr_ptr] <= mem_data_in;
        end
        mem_data_out <= mem[mem_rd_ptr];
    end

    fifo_control #(
        .DATA_WIDTH      (DW),
        .ADDR_WIDTH      (AW),
        .ALMOST_FULL_TH  (6),
        .ALMOST_EMPTY_TH (2)
    ) dut (
        .clk            (clk),
        .reset_L        (reset_L),
        .push           (push),
        .data_in        (data_in),
        .pop            (pop),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .mem_wr_en      (mem_wr_en),
        .mem_data_in    (mem_data_in),
        .mem_wr_ptr     (mem_wr_ptr),
        .mem_rd_ptr     (mem_rd_ptr),
        .mem_data_out   (mem_data_out),
        .empty          (empty),
        .full           (full),
        .almost_empty   (almost_empty),
        .almost_full    (almost_full),
        .count          (count)
`ifdef FIFO_ERR_FLAGS_EN
        ,
        .overflow       (overflow),
        .underflow      (underflow)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string ph);
        chk({ph, " empty"}, 32'(empty), 1);
        chk({ph, " almost_empty"}, 32'(almost_empty), 1);
        chk({ph, " full"}, 32'(full), 0);
        chk({ph, " almost_full"}, 32'(almost_full), 0);
        chk({ph, " count"}, 32'(count), 0);
        chk({ph, " wr_ptr"}, 32'(mem_wr_ptr), 0);
        chk({ph, " rd_ptr"}, 32'(mem_rd_ptr), 0);
        chk({ph, " valid"}, 32'(data_out_valid), 0);
`ifdef FIFO_ERR_FLAGS_EN
        chk({ph, " overflow"}, 32'(overflow), 0);
        chk({ph, " underflow"}, 32'(underflow), 0);
`endif
    endtask

    initial begin
        // Reset held across the first edge
        reset_L = 1'b0;
        #12;
        chk_reset("reset");
        reset_L = 1'b1;

        // Fill 8 words 0x10..0x17 from pointer 0
        for (int i = 0; i < 8; i++) begin
            push    = 1'b1;
            data_in = DW'(16 + i);
            tick();
            chk("fill count", 32'(count), 32'(i + 1));
            chk("fill almost_full", 32'(almost_full), 32'((i + 1) >= 6));
            chk("fill almost_empty", 32'(almost_empty), 32'((i + 1) <= 2));
            chk("fill full", 32'(full), 32'((i + 1) == 8));
        end
        chk("fill wr_ptr wrapped", 32'(mem_wr_ptr), 0);

        // 9th push on full: dropped
        data_in = 8'hEE;
        #1;
        chk("ovf wr_en", 32'(mem_wr_en), 0);
        tick();
        chk("ovf count", 32'(count), 8);
        chk("ovf wr_ptr", 32'(mem_wr_ptr), 0);
        chk("ovf full", 32'(full), 1);
`ifdef FIFO_ERR_FLAGS_EN
        chk("ovf overflow", 32'(overflow), 1);
`endif

        // Push+pop on full: both accepted, oldest word leaves
        data_in = 8'hB8;
        pop     = 1'b1;
        #1;
        chk("fullpp wr_en", 32'(mem_wr_en), 1);
        tick();
        chk("fullpp count", 32'(count), 8);
        chk("fullpp wr_ptr", 32'(mem_wr_ptr), 1);
        chk("fullpp rd_ptr", 32'(mem_rd_ptr), 1);
        chk("fullpp data_out", 32'(data_out), 32'h10);
        chk("fullpp valid", 32'(data_out_valid), 1);
        chk("fullpp full", 32'(full), 1);

        // Drain: 0x11..0x17 then 0xB8
        push = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("drain data_out", 32'(data_out), (i < 7) ? 32'(8'h11 + i) : 32'hB8);
            chk("drain valid", 32'(data_out_valid), 1);
            chk("drain count", 32'(count), 32'(7 - i));
        end
        pop = 1'b0;
        chk("drain empty", 32'(empty), 1);
        chk("drain rd_ptr", 32'(mem_rd_ptr), 1);
`ifdef FIFO_ERR_FLAGS_EN
        chk("drain underflow clear", 32'(underflow), 0);
`endif

        // Push FF, AF, 17 then pop three
        push = 1'b1;
        data_in = 8'hFF; tick();
        data_in = 8'hAF; tick();
        data_in = 8'h17; tick();
        push = 1'b0;
        chk("p3 count", 32'(count), 3);
        chk("p3 valid idle", 32'(data_out_valid), 0);
        chk("p3 almost_empty", 32'(almost_empty), 0);
        pop = 1'b1;
        tick();
        chk("p3 data0", 32'(data_out), 32'hFF);
        chk("p3 valid0", 32'(data_out_valid), 1);
        tick();
        chk("p3 data1", 32'(data_out), 32'hAF);
        chk("p3 valid1", 32'(data_out_valid), 1);
        tick();
        chk("p3 data2", 32'(data_out), 32'h17);
        chk("p3 valid2", 32'(data_out_valid), 1);
        chk("p3 empty", 32'(empty), 1);
        pop = 1'b0;
        tick();
        chk("p3 valid after", 32'(data_out_valid), 0);

        // Push+pop on empty: push lands, pop rejected
        push    = 1'b1;
        pop     = 1'b1;
        data_in = 8'h6A;
        #1;
        chk("emptypp wr_en", 32'(mem_wr_en), 1);
        tick();
        chk("emptypp count", 32'(count), 1);
        chk("emptypp valid", 32'(data_out_valid), 0);
        chk("emptypp empty", 32'(empty), 0);
        chk("emptypp rd_ptr", 32'(mem_rd_ptr), 4);
`ifdef FIFO_ERR_FLAGS_EN
        chk("emptypp underflow", 32'(underflow), 1);
`endif
        push = 1'b0;
        tick();
        chk("emptypp data_out", 32'(data_out), 32'h6A);
        chk("emptypp valid next", 32'(data_out_valid), 1);
        chk("emptypp count next", 32'(count), 0);
        pop = 1'b0;

        // Fill 5, then asynchronous reset between edges
        push = 1'b1;
        for (int i = 0; i < 5; i++) begin
            data_in = DW'(33 + i);
            tick();
        end
        push = 1'b0;
        chk("mid count", 32'(count), 5);
        reset_L = 1'b0;
        #1;
        chk_reset("midreset");
        #2;
        reset_L = 1'b1;

        // Normal operation after reset
        push    = 1'b1;
        data_in = 8'h5A;
        tick();
        push = 1'b0;
        pop  = 1'b1;
        tick();
        chk("post data_out", 32'(data_out), 32'h5A);
        chk("post valid", 32'(data_out_valid), 1);
        chk("post count", 32'(count), 0);
        pop = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fifo_control.md
Name: fifo_control

Overview:
- Pointer/flag controller that sits directly upstream of the FIFO storage memory, which is clocked at `clk`, uses ports FIFO_data_in, wr_ptr, rd_ptr and FIFO_data_out, and registers its read data.
- Accepts push/pop requests from the producer and consumer sides.
- Generates the memory write enable, write pointer and read pointer.
- Tracks occupancy and reports empty/full/almost flags.
- Returns popped words with a valid strobe.

Parameters:
- DATA_WIDTH, 8, word width; must match the memory.
- ADDR_WIDTH, 8, pointer width; DEPTH = 2**ADDR_WIDTH.
- ALMOST_FULL_TH, DEPTH-2, almost_full asserts when count >= this value.
- ALMOST_EMPTY_TH, 2, almost_empty asserts when count <= this value.

Ports:
- clk  in  1  system clock, rising edge.
- reset_L  in  1  asynchronous active-low reset.
- push  in  1  write request.
- data_in  in  DATA_WIDTH  word to write.
- pop  in  1  read request.
- data_out  out  DATA_WIDTH  popped word (pass-through of mem_data_out).
- data_out_valid  out  1  data_out holds a popped word this cycle.
- mem_wr_en  out  1  memory write enable.
- mem_data_in  out  DATA_WIDTH  to memory FIFO_data_in.
- mem_wr_ptr  out  ADDR_WIDTH  to memory wr_ptr.
- mem_rd_ptr  out  ADDR_WIDTH  to memory rd_ptr.
- mem_data_out  in  DATA_WIDTH  from memory FIFO_data_out; registered, mem[rd_ptr] captured at posedge.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- almost_empty  out  1  count <= ALMOST_EMPTY_TH.
- almost_full  out  1  count >= ALMOST_FULL_TH.
- count  out  ADDR_WIDTH+1  current occupancy.
- overflow  out  1  sticky; only with FIFO_ERR_FLAGS_EN.
- underflow  out  1  sticky; only with FIFO_ERR_FLAGS_EN.

Behaviour:
- Interface: one clock `clk`; reset `reset_L` is asynchronous, active-low.
- Reset state:
  - Pointers = 0, count = 0, FSM = VACIO.
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0 (for ALMOST_FULL_TH > 0).
  - data_out_valid = 0, overflow/underflow = 0.
  - Reset mid-operation discards all contents immediately; no memory clearing.
- Write path (combinational):
  - mem_data_in = data_in.
  - mem_wr_en = push & (~full | pop).
  - mem_wr_ptr = write pointer register.
- Accepted push: wr_ptr increments at posedge, wrapping DEPTH-1 -> 0 (natural ADDR_WIDTH overflow).
- Accepted pop:
  - A pop is accepted when pop & ~empty.
  - The memory captures mem[rd_ptr] at the same edge.
  - rd_ptr increments and wraps.
  - data_out_valid is registered high for the following cycle.
  - Read latency: 1 cycle.
- Count and flags:
  - count += accepted push − accepted pop.
  - All flags are registered and derived from the next count.
- Status FSM (VACIO, ACTIVO, LLENO):
  - VACIO -> ACTIVO on accepted push.
  - ACTIVO -> LLENO when the next count = DEPTH.
  - ACTIVO -> VACIO when the next count = 0.
  - LLENO -> ACTIVO on accepted pop without push.
- Simultaneous events:
  - Push+pop when empty: push accepted, pop rejected (underflow).
  - Push+pop when full: both accepted; count unchanged, stays LLENO.
  - Push+pop otherwise: both accepted; count unchanged.
- Push on full without pop: word dropped, no pointer change.
- Pop on empty: ignored; data_out_valid stays 0.
- A word pushed at edge N is poppable at edge N+1; the memory write precedes the read capture by one edge.

Optional Feature:
- Macro: FIFO_ERR_FLAGS_EN.
- Defined:
  - overflow and underflow ports exist.
  - overflow sets on push & full & ~pop; underflow sets on pop & empty.
  - Both flags stay set until reset_L.
- Undefined: ports absent; illegal requests are silently ignored with identical pointer/count behaviour.

Decomposition:
- Package fifo_pkg:
  - FIFO status state encoding (VACIO = 2'b00, ACTIVO = 2'b01, LLENO = 2'b10).
  - Default width constants.
- Sub-module fifo_ptr: ADDR_WIDTH wrap-around pointer register with async reset and increment enable, instantiated for the write and read pointers.

Test Plan:
- Scenario parameters: ADDR_WIDTH=3 (DEPTH 8), ALMOST_FULL_TH=6, ALMOST_EMPTY_TH=2, FIFO_ERR_FLAGS_EN defined.
- Reset: hold reset_L=0 -> empty=1, almost_empty=1, full=0, count=0, wr_ptr=rd_ptr=0, data_out_valid=0.
- Push 8'hFF, 8'hAF, 8'h17 on consecutive cycles, then pop 3 -> data_out FF, AF, 17, each with valid 1 cycle after its pop; empty returns to 1.
- Push 8 words -> full=1 and almost_full=1 at count 6; 9th push -> count stays 8, overflow=1, wr_ptr unchanged.
- Full FIFO, push 8'hB8 + pop same cycle -> count stays 8; wr_ptr 0 -> 1 (wrap); oldest word out.
- Empty FIFO, push 8'h6A + pop same cycle -> count=1, underflow=1, no valid; next-cycle pop -> data_out=6A.
- Fill 5 words, assert reset_L=0 mid-stream -> all state back to reset values asynchronously, before the next clk edge.
